// File: rtl/memory_responder.sv
// -----------------------------------------------------------------------------
// memory_responder
//
// Memory-side responder for the MiniSRC datapath MAR/MDR strobes. It answers
// read and write requests against a word-addressed synchronous RAM. A request
// is accepted in IDLE, waits WAIT_STATES cycles, and completes with a one-cycle
// RESP state in which done pulses. Read data (Mdatain for the MDR) is
// registered and holds until the next completed read.
//
// Parameters:
//   DATA_WIDTH  - word width (matches MDR / BusMuxOut)
//   ADDR_WIDTH  - MAR address bits used
//   MEM_DEPTH   - implemented words, must be <= 2**ADDR_WIDTH
//   WAIT_STATES - extra cycles between accept and done, legal range 0..15
//
// Ports:
//   clock  in   rising-edge clock
//   clear  in   asynchronous active-low reset
//   read   in   read request strobe
//   write  in   write request strobe
//   addr   in   word address from MAR
//   wdata  in   write data from MDR
//   rdata  out  registered read data, valid while done is high after a read
//   done   out  one-cycle completion pulse (high exactly in RESP)
//   busy   out  high in WAIT or RESP
//   err    out  one-cycle error pulse: both strobes at once, or an
//               out-of-range address (then together with done)
// -----------------------------------------------------------------------------
module memory_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 9,
  parameter int MEM_DEPTH   = 512,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  read,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  done,
  output logic                  busy,
  output logic                  err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int AW1   = ADDR_WIDTH + 1;
  // One extra bit so MEM_DEPTH == 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0] DEPTH_L = AW1'(MEM_DEPTH);
  localparam logic [3:0]          WS_L    = 4'(WAIT_STATES);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q,   cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  op_wr_q, op_wr_d;
  logic                  armed_q, armed_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  done_q,  done_d;
  logic                  busy_q,  busy_d;
  logic                  err_q,   err_d;

  logic                  enter_resp;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic                  acc_write;
  logic                  in_range;
  logic [IDX_W-1:0]      mem_idx;
  logic                  mem_we;

  // With WAIT_STATES=0 the RESP-entry edge is the accept edge itself, so the
  // access must use the live request rather than the not-yet-latched copy.
  always_comb begin
    if (state_q == S_IDLE) begin
      acc_addr  = addr;
      acc_wdata = wdata;
      acc_write = write;
    end else begin
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_write = op_wr_q;
    end
  end

  assign in_range = ({1'b0, acc_addr} < DEPTH_L);
  assign mem_idx  = acc_addr[IDX_W-1:0];

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    op_wr_d    = op_wr_q;
    armed_d    = armed_q;
    rdata_d    = rdata_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    enter_resp = 1'b0;
    mem_we     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (armed_q && (read ^ write)) begin
          addr_d  = addr;
          wdata_d = wdata;
          op_wr_d = write;
          cnt_d   = WS_L;
          armed_d = 1'b0;
          if (WAIT_STATES == 0) enter_resp = 1'b1;
          else                  state_d    = S_WAIT;
        end else if (armed_q && read && write) begin
          // Ambiguous request: flag it and wait for both strobes to drop.
          err_d   = 1'b1;
          armed_d = 1'b0;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) enter_resp = 1'b1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Re-arm only after an idle gap on both strobes, so a strobe held through
    // done cannot launch a second access.
    if (!read && !write) armed_d = 1'b1;

    if (enter_resp) begin
      state_d = S_RESP;
      done_d  = 1'b1;
      err_d   = !in_range;
      if (acc_write) mem_we  = in_range;
      else           rdata_d = in_range ? mem[mem_idx] : '0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      op_wr_q <= 1'b0;
      armed_q <= 1'b1;
      rdata_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: state flops use non-blocking assignments so every flop samples
      // the pre-edge values, independent of statement order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      op_wr_q <= op_wr_d;
      armed_q <= armed_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  // NOTE: the RAM array has no reset; contents survive clear, and leaving it
  // out lets the array map onto block/distributed RAM. A write only happens on
  // the RESP-entry edge, so clear during WAIT aborts before any RAM change.
  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_idx] <= acc_wdata;
  end

  assign rdata = rdata_q;
  assign done  = done_q;
  assign busy  = busy_q;
  assign err   = err_q;

endmodule

// File: tb/tb_memory_responder.sv
// -----------------------------------------------------------------------------
// tb_memory_responder
//
// Directed bench for memory_responder. Instance u_dut_a uses WAIT_STATES=2
// with a 10-bit address so out-of-range addresses (>= 512) can be driven;
// instance u_dut_b uses WAIT_STATES=0 for the single-cycle response case.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_memory_responder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: WAIT_STATES=2, ADDR_WIDTH=10, MEM_DEPTH=512
  logic        clear_a, read_a, write_a;
  logic [9:0]  addr_a;
  logic [31:0] wdata_a, rdata_a;
  logic        done_a, busy_a, err_a;

  // Instance B: WAIT_STATES=0, ADDR_WIDTH=9, MEM_DEPTH=512
  logic        clear_b, read_b, write_b;
  logic [8:0]  addr_b;
  logic [31:0] wdata_b, rdata_b;
  logic        done_b, busy_b, err_b;

  memory_responder #(
    .DATA_WIDTH(32), .ADDR_WIDTH(10), .MEM_DEPTH(512), .WAIT_STATES(2)
  ) u_dut_a (
    .clock(clk), .clear(clear_a), .read(read_a), .write(write_a),
    .addr(addr_a), .wdata(wdata_a), .rdata(rdata_a),
    .done(done_a), .busy(busy_a), .err(err_a)
  );

  memory_responder #(
    .DATA_WIDTH(32), .ADDR_WIDTH(9), .MEM_DEPTH(512), .WAIT_STATES(0)
  ) u_dut_b (
    .clock(clk), .clear(clear_b), .read(read_b), .write(write_b),
    .addr(addr_b), .wdata(wdata_b), .rdata(rdata_b),
    .done(done_b), .busy(busy_b), .err(err_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete request on instance A (sel=0) or B (sel=1). Raises the strobe,
  // counts cycles after the accept edge until done (bounded), captures rdata
  // and err in the done cycle, then drops the strobes and checks done/busy fall.
  task automatic access(input string tag, input bit sel, input bit is_wr,
                        input logic [9:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] rd,
                        output logic er);
    logic d_now, b_now;
    lat = 0;
    rd  = 'x;
    er  = 1'bx;
    if (sel) begin
      addr_b = a[8:0]; wdata_b = d; read_b = !is_wr; write_b = is_wr;
    end else begin
      addr_a = a;      wdata_a = d; read_a = !is_wr; write_a = is_wr;
    end
    for (int i = 1; i <= 20; i++) begin
      tick();
      d_now = sel ? done_b : done_a;
      b_now = sel ? busy_b : busy_a;
      if (i == 1) check({tag, "_busy1"}, 32'(b_now), 32'd1);
      if (d_now) begin
        lat = i;
        rd  = sel ? rdata_b : rdata_a;
        er  = sel ? err_b   : err_a;
        break;
      end
    end
    read_a = 1'b0; write_a = 1'b0; read_b = 1'b0; write_b = 1'b0;
    tick();
    check({tag, "_done_fall"}, 32'(sel ? done_b : done_a), 32'd0);
    check({tag, "_busy_fall"}, 32'(sel ? busy_b : busy_a), 32'd0);
  endtask

  int          lat;
  logic [31:0] rd;
  logic        er;
  int          pulses;

  initial begin
    clear_a = 1'b0; read_a = 1'b0; write_a = 1'b0; addr_a = '0; wdata_a = '0;
    clear_b = 1'b0; read_b = 1'b0; write_b = 1'b0; addr_b = '0; wdata_b = '0;
    tick();
    tick();

    // Reset state
    check("rst_rdata", rdata_a, 32'h0);
    check("rst_done",  32'(done_a), 32'd0);
    check("rst_busy",  32'(busy_a), 32'd0);
    check("rst_err",   32'(err_a),  32'd0);
    clear_a = 1'b1;
    clear_b = 1'b1;
    tick();

    // 1: write then read addr 5, done in the 3rd cycle after accept
    access("t1_wr", 0, 1, 10'd5, 32'hDEADBEEF, lat, rd, er);
    check("t1_wr_lat", lat, 3);
    check("t1_wr_err", 32'(er), 32'd0);
    access("t1_rd", 0, 0, 10'd5, 32'h0, lat, rd, er);
    check("t1_rd_lat",   lat, 3);
    check("t1_rd_rdata", rd, 32'hDEADBEEF);
    check("t1_rd_err",   32'(er), 32'd0);

    // 3: read held for 10 cycles gives one done; re-raise after a gap gives one more
    access("t3_wr", 0, 1, 10'd3, 32'hA5A50003, lat, rd, er);
    addr_a = 10'd3;
    read_a = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done_a) pulses++;
    end
    check("t3_hold_pulses", pulses, 1);
    check("t3_hold_rdata",  rdata_a, 32'hA5A50003);
    read_a = 1'b0;
    tick();
    read_a = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done_a) pulses++;
    end
    check("t3_rearm_pulses", pulses, 1);
    read_a = 1'b0;
    tick();

    // 4: both strobes in IDLE -> one-cycle err, no access
    addr_a  = 10'd5;
    wdata_a = 32'hFFFFFFFF;
    read_a  = 1'b1;
    write_a = 1'b1;
    tick();
    check("t4_err",   32'(err_a),  32'd1);
    check("t4_done",  32'(done_a), 32'd0);
    check("t4_busy",  32'(busy_a), 32'd0);
    tick();
    check("t4_err_1cyc", 32'(err_a),  32'd0);
    check("t4_done2",    32'(done_a), 32'd0);
    read_a  = 1'b0;
    write_a = 1'b0;
    tick();
    check("t4_rdata_kept", rdata_a, 32'hA5A50003);
    access("t4_rd", 0, 0, 10'd5, 32'h0, lat, rd, er);
    check("t4_ram_kept", rd, 32'hDEADBEEF);

    // 5: out-of-range read/write; 600 aliases 88 in the low 9 bits
    access("t5_pre", 0, 1, 10'd88, 32'h00000088, lat, rd, er);
    access("t5_rd", 0, 0, 10'd600, 32'h0, lat, rd, er);
    check("t5_rd_lat",   lat, 3);
    check("t5_rd_err",   32'(er), 32'd1);
    check("t5_rd_rdata", rd, 32'h0);
    access("t5_rd88", 0, 0, 10'd88, 32'h0, lat, rd, er);
    check("t5_rd88_rdata", rd, 32'h00000088);
    access("t5_wr", 0, 1, 10'd600, 32'hCAFEF00D, lat, rd, er);
    check("t5_wr_lat",   lat, 3);
    check("t5_wr_err",   32'(er), 32'd1);
    check("t5_wr_rdata", rd, 32'h00000088);
    access("t5_chk", 0, 0, 10'd88, 32'h0, lat, rd, er);
    check("t5_no_alias", rd, 32'h00000088);

    // 6: clear during WAIT aborts a write
    access("t6_pre", 0, 1, 10'd7, 32'h11110007, lat, rd, er);
    addr_a  = 10'd7;
    wdata_a = 32'h12345678;
    write_a = 1'b1;
    tick();
    check("t6_busy_wait", 32'(busy_a), 32'd1);
    write_a = 1'b0;
    clear_a = 1'b0;
    #1;
    check("t6_rst_busy",  32'(busy_a), 32'd0);
    check("t6_rst_done",  32'(done_a), 32'd0);
    check("t6_rst_err",   32'(err_a),  32'd0);
    check("t6_rst_rdata", rdata_a, 32'h0);
    tick();
    tick();
    clear_a = 1'b1;
    tick();
    access("t6_rd", 0, 0, 10'd7, 32'h0, lat, rd, er);
    check("t6_old_data", rd, 32'h11110007);

    // 2: WAIT_STATES=0, preload addr 0, reset, then single-cycle read
    access("t2_wr", 1, 1, 10'd0, 32'h00000011, lat, rd, er);
    check("t2_wr_lat", lat, 1);
    clear_b = 1'b0;
    tick();
    check("t2_rst_rdata", rdata_b, 32'h0);
    clear_b = 1'b1;
    tick();
    access("t2_rd", 1, 0, 10'd0, 32'h0, lat, rd, er);
    check("t2_rd_lat",   lat, 1);
    check("t2_rd_rdata", rd, 32'h00000011);
    check("t2_rd_err",   32'(er), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
